// File: rtl/seg7_scan_arb.sv
// seg7_scan_arb
// Drives a three-digit, seven-segment display that two requesters share.
// A free-running prescaler divides the clock into digit slots. A frame is
// three slots long, one per digit. At the start of each frame the block picks
// an owner with round-robin arbitration and copies that owner's value and
// decimal points into shadow registers. The shadow copy stays fixed for the
// rest of the frame.
//
// Optional feature: define SEG_BLANK_EN to turn the display off for the first
// BLANK_CYC clocks of every digit slot. This reduces ghosting between digits.
//
// Ports
//   clk_i          clock
//   rstn_i         asynchronous active-low reset
//   req_i[1:0]     display requests, bit n = requester n
//   val0_i/val1_i  three hex digits per requester, digit i = bits [4i+3:4i]
//   dp0_i/dp1_i    decimal point per digit, 1 = lit
//   gnt_o[1:0]     one-hot owner of the frame being shown, 00 = none
//   frame_o        one-clock pulse when a frame completes
//   seg_display_o  {dp, g..a} after polarity
//   seg_sel_o      one-hot digit enable, active-high
module seg7_scan_arb #(
  parameter byte CLK_IN_MHZ   = 125,
  parameter bit  LED_POLARITY = 1'b0,
  parameter int  SCAN_HZ      = 1000,
  parameter int  BLANK_CYC    = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [1:0]  req_i,
  input  logic [11:0] val0_i,
  input  logic [11:0] val1_i,
  input  logic [2:0]  dp0_i,
  input  logic [2:0]  dp1_i,
  output logic [1:0]  gnt_o,
  output logic        frame_o,
  output logic [7:0]  seg_display_o,
  output logic [2:0]  seg_sel_o
);

  localparam int             TICK_DIV  = int'(CLK_IN_MHZ) * 1000000 / SCAN_HZ;
  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]     SEG_OFF   = LED_POLARITY ? 8'h00 : 8'hFF;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [1:0]    digit_q, digit_d;
  logic [11:0]   sh_val_q, sh_val_d;
  logic [2:0]    sh_dp_q, sh_dp_d;
  logic [1:0]    own_q, own_d;
  logic          pref_q, pref_d;
  logic [1:0]    pick;
  logic          start;
  logic          frame_d;
  logic          blank;
  logic [3:0]    nib;
  logic          dp_bit;
  logic [2:0]    sel_d;
  logic [7:0]    seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] polarize(input logic [7:0] raw);
    polarize = LED_POLARITY ? raw : ~raw;
  endfunction

  assign tick    = (presc_q == TICK_LAST);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // On a tie, grant the requester that pref_q favours. pref_q points away
  // from the previous owner and returns to requester 0 whenever the block
  // goes idle.
  always_comb begin
    pick = 2'b00;
    case (req_i)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = pref_q ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    own_d    = own_q;
    pref_d   = pref_q;
    frame_d  = 1'b0;
    start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && (req_i != 2'b00)) start = 1'b1;
      end
      SCAN: begin
        if (tick) begin
          if (digit_q == 2'd2) begin
            frame_d = 1'b1;
            if (req_i == 2'b00) begin
              state_d = IDLE;
              digit_d = 2'd0;
              own_d   = 2'b00;
              pref_d  = 1'b0;
            end else begin
              start = 1'b1;
            end
          end else begin
            digit_d = digit_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d  = SCAN;
      digit_d  = 2'd0;
      own_d    = pick;
      pref_d   = pick[0];
      sh_val_d = pick[1] ? val1_i : val0_i;
      sh_dp_d  = pick[1] ? dp1_i : dp0_i;
    end
  end

`ifdef SEG_BLANK_EN
  // presc_d is the slot position that the registered outputs will show.
  assign blank = (int'(presc_d) < BLANK_CYC);
`else
  logic unused_blank;
  assign unused_blank = ^BLANK_CYC;
  assign blank        = 1'b0;
`endif

  // The output registers take their values from the next-state signals,
  // so they change on the same edge as the state.
  always_comb begin
    nib    = 4'h0;
    dp_bit = 1'b0;
    sel_d  = 3'b000;
    seg_d  = SEG_OFF;
    case (digit_d)
      2'd0:    begin nib = sh_val_d[3:0];  dp_bit = sh_dp_d[0]; end
      2'd1:    begin nib = sh_val_d[7:4];  dp_bit = sh_dp_d[1]; end
      default: begin nib = sh_val_d[11:8]; dp_bit = sh_dp_d[2]; end
    endcase
    if ((state_d == SCAN) && !blank) begin
      sel_d = 3'b001 << digit_d;
      seg_d = polarize({dp_bit, hex7(nib)});
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q       <= '0;
      state_q       <= IDLE;
      digit_q       <= 2'd0;
      sh_val_q      <= '0;
      sh_dp_q       <= '0;
      own_q         <= 2'b00;
      pref_q        <= 1'b0;
      gnt_o         <= 2'b00;
      frame_o       <= 1'b0;
      seg_sel_o     <= 3'b000;
      seg_display_o <= SEG_OFF;
    end else begin
      presc_q       <= presc_d;
      state_q       <= state_d;
      digit_q       <= digit_d;
      sh_val_q      <= sh_val_d;
      sh_dp_q       <= sh_dp_d;
      own_q         <= own_d;
      pref_q        <= pref_d;
      gnt_o         <= own_d;
      frame_o       <= frame_d;
      seg_sel_o     <= sel_d;
      seg_display_o <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_arb.sv
module tb_seg7_scan_arb;

  localparam byte MHZ = 1;
  localparam int  HZ  = 250000;
  localparam int  BLK = 1;
  localparam int  DIV = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req;
  logic [11:0] v0, v1;
  logic [2:0]  d0, d1;

  logic [1:0] gnt_h, gnt_l;
  logic       frm_h, frm_l;
  logic [7:0] seg_h, seg_l;
  logic [2:0] sel_h, sel_l;

  always #5 clk = ~clk;

  seg7_scan_arb #(.CLK_IN_MHZ(MHZ), .LED_POLARITY(1'b1), .SCAN_HZ(HZ), .BLANK_CYC(BLK)) dut_h (
    .clk_i(clk), .rstn_i(rstn), .req_i(req), .val0_i(v0), .val1_i(v1),
    .dp0_i(d0), .dp1_i(d1), .gnt_o(gnt_h), .frame_o(frm_h),
    .seg_display_o(seg_h), .seg_sel_o(sel_h));

  seg7_scan_arb #(.CLK_IN_MHZ(MHZ), .LED_POLARITY(1'b0), .SCAN_HZ(HZ), .BLANK_CYC(BLK)) dut_l (
    .clk_i(clk), .rstn_i(rstn), .req_i(req), .val0_i(v0), .val1_i(v1),
    .dp0_i(d0), .dp1_i(d1), .gnt_o(gnt_l), .frame_o(frm_l),
    .seg_display_o(seg_l), .seg_sel_o(sel_l));

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Frame-level reference: a frame is 3*DIV clocks, starts on a tick, and
  // takes a snapshot of the owner's inputs when it starts.
  int          k;       // edges since reset release; a tick falls on k%DIV==DIV-1
  bit          act;
  int          fst;     // edge index at which the current frame started
  int          pos;     // position within the frame after the latest edge
  int          fown;
  int          pref;
  bit          fpulse;
  logic [11:0] fval;
  logic [2:0]  fdp;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; act = 0; fst = 0; pos = 0; fown = 0; pref = 0; fpulse = 0;
    fval = '0; fdp = '0;
  endtask

  task automatic start_frame();
    if (req == 2'b11) fown = pref;
    else fown = (req == 2'b10) ? 1 : 0;
    pref = 1 - fown;
    fval = fown ? v1 : v0;
    fdp  = fown ? d1 : d0;
    fst  = k;
    act  = 1;
  endtask

  task automatic model_edge();
    fpulse = 0;
    if (k % DIV == DIV - 1) begin
      if (act && (k - fst == 3 * DIV)) begin
        fpulse = 1;
        if (req == 2'b00) begin act = 0; pref = 0; end
        else start_frame();
      end else if (!act && req != 2'b00) begin
        start_frame();
      end
    end
    pos = k - fst;
    k++;
  endtask

  task automatic check_all();
    logic [7:0] raw, eh, el;
    logic [2:0] esel;
    logic [1:0] egnt;
    int slot;
    bit blank;
    blank = 0;
`ifdef SEG_BLANK_EN
    blank = (pos % DIV) < BLK;
`endif
    esel = 3'b000; eh = 8'h00; el = 8'hFF;
    egnt = act ? 2'(1 << fown) : 2'b00;
    if (act && !blank) begin
      slot = pos / DIV;
      raw  = {fdp[slot], lut[fval[4*slot +: 4]]};
      esel = 3'(1 << slot);
      eh   = raw;
      el   = ~raw;
    end
    chk("sel_h",   {5'b0, sel_h}, {5'b0, esel});
    chk("seg_h",   seg_h,         eh);
    chk("gnt_h",   {6'b0, gnt_h}, {6'b0, egnt});
    chk("frame_h", {7'b0, frm_h}, {7'b0, fpulse});
    chk("sel_l",   {5'b0, sel_l}, {5'b0, esel});
    chk("seg_l",   seg_l,         el);
    chk("gnt_l",   {6'b0, gnt_l}, {6'b0, egnt});
    chk("frame_l", {7'b0, frm_l}, {7'b0, fpulse});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_sel_l",   {5'b0, sel_l}, 8'h00);
    chk("rst_seg_l",   seg_l,         8'hFF);
    chk("rst_gnt_l",   {6'b0, gnt_l}, 8'h00);
    chk("rst_frame_l", {7'b0, frm_l}, 8'h00);
    chk("rst_seg_h",   seg_h,         8'h00);
    chk("rst_sel_h",   {5'b0, sel_h}, 8'h00);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    rstn = 1'b0; req = 2'b00; v0 = '0; v1 = '0; d0 = '0; d1 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rstn = 1'b1;
    model_reset();

    // Idle with no requests
    step(10);

    // Single requester 0: 1A5 with dp on digit 0
    req = 2'b01; v0 = 12'h1A5; d0 = 3'b001;
    step(40);

    // Both requesting: ownership alternates frame by frame
    v1 = 12'hC3E; d1 = 3'b110;
    req = 2'b11;
    step(60);

    // Value change partway through a frame is deferred
    req = 2'b01; v0 = 12'h123; d0 = 3'b000;
    step(17);
    v0 = 12'h456;
    step(30);

    // Requests drop mid-frame: the frame still completes
    step(5);
    req = 2'b00;
    step(30);

    // Reset in the middle of a frame
    req = 2'b11; v0 = 12'h789; v1 = 12'hDEF;
    step(18);
    do_reset();
    step(30);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) req = 2'($urandom);
      if ($urandom_range(0, 3) == 0) v0 = 12'($urandom);
      if ($urandom_range(0, 3) == 0) v1 = 12'($urandom);
      if ($urandom_range(0, 5) == 0) d0 = 3'($urandom);
      if ($urandom_range(0, 5) == 0) d1 = 3'($urandom);
      step(1);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_arb.md
SEG7_SCAN_ARB -- requirements
Module: seg7_scan_arb

Interface
REQ-001 SHALL have parameter CLK_IN_MHZ, byte, default 125: input clock frequency in MHz.
REQ-002 SHALL have parameter LED_POLARITY, bit, default 1'b0: 1 = segments active-high, 0 = segments active-low (inverted).
REQ-003 SHALL have parameter SCAN_HZ, int, default 1000: digit-slot rate; TickDiv = CLK_IN_MHZ*1000000/SCAN_HZ clocks per slot, TickDiv >= 2.
REQ-004 SHALL have parameter BLANK_CYC, int, default 4: inter-digit blanking length in clocks, BLANK_CYC < TickDiv.
REQ-005 SHALL have port clk_i  input  1: single clock; all logic is in this domain.
REQ-006 SHALL have port rstn_i  input  1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port req_i  input  2: display requests; bit n = requester n.
REQ-008 SHALL have ports val0_i and val1_i  input  12: 3 hex digits per requester; digit i = bits [4i+3:4i].
REQ-009 SHALL have ports dp0_i and dp1_i  input  3: decimal point per digit, 1 = lit.
REQ-010 SHALL have port gnt_o  output  2: one-hot owner of the current frame, 00 = none.
REQ-011 SHALL have port frame_o  output  1: one-clock pulse at the end of each displayed frame.
REQ-012 SHALL have port seg_display_o  output  8: bits[6:0] = segments a-g, bit7 = dp, after polarity.
REQ-013 SHALL have port seg_sel_o  output  3: one-hot digit enable, active-high.

Function
REQ-014 SHALL run a free prescaler 0..TickDiv-1 from reset; tick = prescaler at TickDiv-1.
REQ-015 SHALL implement states IDLE and SCAN; all outputs registered and updated on the edge that samples tick.
REQ-016 IDLE: seg_sel_o=000, seg_display_o=OFF (8'h00 if LED_POLARITY=1, 8'hFF if 0), gnt_o=00.
REQ-017 IDLE + tick + req_i!=0: grant per REQ-019, latch owner's val/dp into shadow registers, digit=0, go to SCAN.
REQ-018 SCAN: each tick advances digit 0->1->2; on tick at digit 2: frame_o=1 for one clock, re-arbitrate; req_i=00 -> IDLE, else relatch and restart at digit 0.
REQ-019 Arbitration: single requester wins; both requesting -> grant the one that did not own the previous frame; after reset or IDLE, requester 0 wins ties.
REQ-020 Shadow value/dp/gnt SHALL change only at frame start; val/dp changes and req drops mid-frame are ignored until frame end.
REQ-021 Digit i: seg_sel_o bit i only; segments = hex decode of nibble i (0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71), bit7 = dp[i]; inverted when LED_POLARITY=0.

Reset
REQ-022 rstn_i low SHALL asynchronously force: prescaler=0, state IDLE, digit=0, shadow regs=0, round-robin pointer favouring requester 0, gnt_o=00, frame_o=0, seg_sel_o=000, seg_display_o=OFF.
REQ-023 Reset mid-frame SHALL abandon the frame without a frame_o pulse; operation resumes from IDLE after release.

Configuration
REQ-024 Macro SEG_BLANK_EN defined: during the first BLANK_CYC clocks of each SCAN digit slot, seg_sel_o=000 and seg_display_o=OFF; the slot length is unchanged.
REQ-025 Macro SEG_BLANK_EN undefined: no blanking; BLANK_CYC unused; digit drive lasts the full slot.

Verification (CLK_IN_MHZ=1, SCAN_HZ=250000 -> TickDiv=4)
REQ-026 Reset with LED_POLARITY=0 -> seg_sel_o=000, seg_display_o=8'hFF, gnt_o=00, frame_o=0.
REQ-027 LED_POLARITY=1, req_i=01, val0=12'h1A5, dp0=001 -> slots sel 001/ED, 010/77, 100/06; gnt_o=01; frame_o every 12 clocks.
REQ-028 req_i=11 held -> gnt_o alternates 01,10,01,10 on consecutive frames, each frame 12 clocks.
REQ-029 val0 changes 12'h123->12'h456 mid-digit-1 -> current frame shows digit2=1; next frame shows 6,5,4.
REQ-030 req_i drops to 00 mid-frame -> frame completes, frame_o pulses, then IDLE with seg_sel_o=000 and gnt_o=00.
REQ-031 SEG_BLANK_EN, BLANK_CYC=1 -> first clock of every slot seg_sel_o=000 and display OFF; remaining 3 clocks drive the digit.
